// File: rtl/rename_reg_file_mp_pkg.sv
// rtl/rename_reg_file_mp_pkg.sv - shared widths and defaults for the rename register file
package rename_reg_file_mp_pkg;

  localparam int RF_XLEN      = 32;
  localparam int RF_NUM_REGS  = 32;
  localparam int RF_ROB_IDX_W = 4;
  localparam int RF_NUM_RD    = 2;
  localparam int RF_NUM_CM    = 2;
  localparam int RF_REG_IDX_W = $clog2(RF_NUM_REGS);

  typedef logic [RF_REG_IDX_W-1:0] reg_idx_t;

  // Offset of port p's field inside a packed multi-port bus of width w per port.
  function automatic int port_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/rename_reg_file_mp_rf_read_bypass.sv
// rtl/rename_reg_file_mp_rf_read_bypass.sv - per-read-port commit bypass and x0 forcing
module rf_read_bypass
  import rename_reg_file_mp_pkg::*;
#(
  parameter int XLEN      = RF_XLEN,
  parameter int RW        = RF_REG_IDX_W,
  parameter int ROB_IDX_W = RF_ROB_IDX_W,
  parameter int NUM_CM    = RF_NUM_CM
) (
  input  logic [RW-1:0]               q_addr,
  input  logic                        st_busy,
  input  logic [ROB_IDX_W-1:0]        st_tag,
  input  logic [XLEN-1:0]             st_val,
  input  logic [NUM_CM-1:0]           cm_en,
  input  logic [NUM_CM*RW-1:0]        cm_rd,
  input  logic [NUM_CM*ROB_IDX_W-1:0] cm_rob_idx,
  input  logic [NUM_CM*XLEN-1:0]      cm_val,
  output logic                        busy,
  output logic [ROB_IDX_W-1:0]        rob_idx,
  output logic [XLEN-1:0]             val
);

  logic            hit;
  logic [XLEN-1:0] hit_val;

  // Ascending scan so the youngest (highest-index) qualifying commit wins.
  always_comb begin
    hit     = 1'b0;
    hit_val = '0;
    for (int c = 0; c < NUM_CM; c++) begin
      if (cm_en[c] && st_busy && (q_addr != '0) &&
          (cm_rd[port_lsb(c, RW) +: RW] == q_addr) &&
          (cm_rob_idx[port_lsb(c, ROB_IDX_W) +: ROB_IDX_W] == st_tag)) begin
        hit     = 1'b1;
        hit_val = cm_val[port_lsb(c, XLEN) +: XLEN];
      end
    end
  end

  always_comb begin
    busy    = 1'b0;
    rob_idx = '0;
    val     = '0;
    if (q_addr == '0) begin
      busy    = 1'b0;
    end else if (hit) begin
      val     = hit_val;
    end else begin
      busy    = st_busy;
      rob_idx = st_busy ? st_tag : '0;
      val     = st_val;
    end
  end

endmodule

// File: rtl/rename_reg_file_mp.sv
// rtl/rename_reg_file_mp.sv - multi-port register file with busy/ROB-tag rename tracking
module rename_reg_file_mp
  import rename_reg_file_mp_pkg::*;
#(
  parameter int XLEN      = RF_XLEN,
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int ROB_IDX_W = RF_ROB_IDX_W,
  parameter int NUM_RD    = RF_NUM_RD,
  parameter int NUM_CM    = RF_NUM_CM,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        roll_back,
  input  logic                        iss_en,
  input  logic [RW-1:0]               iss_rd,
  input  logic [ROB_IDX_W-1:0]        iss_rob_idx,
  input  logic [NUM_RD*RW-1:0]        rd_addr,
  output logic [NUM_RD-1:0]           rd_busy,
  output logic [NUM_RD*ROB_IDX_W-1:0] rd_rob_idx,
  output logic [NUM_RD*XLEN-1:0]      rd_val,
  input  logic [NUM_CM-1:0]           cm_en,
  input  logic [NUM_CM*RW-1:0]        cm_rd,
  input  logic [NUM_CM*ROB_IDX_W-1:0] cm_rob_idx,
  input  logic [NUM_CM*XLEN-1:0]      cm_val
);

  logic [NUM_REGS-1:0]                 busy;
  logic [NUM_REGS-1:0][ROB_IDX_W-1:0]  tag;
  logic [NUM_REGS-1:0][XLEN-1:0]       value;
  logic [NUM_RD-1:0][RW-1:0]           q_addr;

  // Statement order sets priority: later commit ports override earlier ones,
  // and issue overrides any commit busy-clear on the same register.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      busy   <= '0;
      tag    <= '0;
      value  <= '0;
      q_addr <= '0;
    end else if (rdy_in) begin
      for (int p = 0; p < NUM_RD; p++) begin
        q_addr[p] <= rd_addr[port_lsb(p, RW) +: RW];
      end
      for (int c = 0; c < NUM_CM; c++) begin
        if (cm_en[c] && (cm_rd[port_lsb(c, RW) +: RW] != '0)) begin
          value[cm_rd[port_lsb(c, RW) +: RW]] <= cm_val[port_lsb(c, XLEN) +: XLEN];
          if (cm_rob_idx[port_lsb(c, ROB_IDX_W) +: ROB_IDX_W] ==
              tag[cm_rd[port_lsb(c, RW) +: RW]]) begin
            busy[cm_rd[port_lsb(c, RW) +: RW]] <= 1'b0;
          end
        end
      end
      if (roll_back) begin
        busy <= '0;
      end else if (iss_en && (iss_rd != '0)) begin
        busy[iss_rd] <= 1'b1;
        tag[iss_rd]  <= iss_rob_idx;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_bypass #(
      .XLEN      (XLEN),
      .RW        (RW),
      .ROB_IDX_W (ROB_IDX_W),
      .NUM_CM    (NUM_CM)
    ) u_bypass (
      .q_addr     (q_addr[p]),
      .st_busy    (busy[q_addr[p]]),
      .st_tag     (tag[q_addr[p]]),
      .st_val     (value[q_addr[p]]),
      .cm_en      (cm_en),
      .cm_rd      (cm_rd),
      .cm_rob_idx (cm_rob_idx),
      .cm_val     (cm_val),
      .busy       (rd_busy[p]),
      .rob_idx    (rd_rob_idx[p*ROB_IDX_W +: ROB_IDX_W]),
      .val        (rd_val[p*XLEN +: XLEN])
    );
  end

endmodule
